// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 VGA640_* timing constants and line/frame length helper
package vga_timing_pkg;
  localparam int VGA640_DIV       = 2;
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  function automatic int total(int vis, int front, int sync, int back);
    return vis + front + sync + back;
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle (pix_ce, x, y, hsync, vsync, de, line_start, frame_start, frame_cnt); master drives, slave consumes
interface vga_timing_if #(parameter int CNT_W = 11, parameter int FRAME_W = 8);
  logic               pix_ce;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  modport master(output pix_ce, x, y, hsync, vsync, de, line_start, frame_start, frame_cnt);
  modport slave(input pix_ce, x, y, hsync, vsync, de, line_start, frame_start, frame_cnt);
endinterface

// File: rtl/pixel_ce_gen.sv
// pixel_ce_gen: registered one-cycle pixel enable every DIV clocks (CLOCK_50, reset in; pix_ce_o out; constant 1 when DIV=1)
module pixel_ce_gen #(
  parameter int DIV = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic pix_ce_o
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_ce_q;
  assign div_cnt_d = (reset || div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
  always_ff @(posedge CLOCK_50) begin
    div_cnt_q <= div_cnt_d;
    pix_ce_q  <= reset ? (DIV == 1) : (div_cnt_d == LAST);
  end
  assign pix_ce_o = pix_ce_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing (CLOCK_50, reset in; vga_timing_if.master out); VGA_TIMING_PIPE_EN adds one pixel of output latency
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV       = VGA640_DIV,
  parameter int H_VISIBLE = VGA640_H_VISIBLE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_VISIBLE = VGA640_V_VISIBLE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 8
) (
  input logic          CLOCK_50,
  input logic          reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  if (H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W) begin : g_cnt_w_err
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   HV  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0]   HS0 = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0]   HS1 = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0]   VV  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0]   VS0 = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0]   VS1 = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  logic               pix_ce;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W:0]     xe, ye;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic               ls_q, ls_d, fs_q, fs_d, first_q, first_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  pixel_ce_gen #(.DIV(DIV)) u_pixel_ce_gen (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .pix_ce_o(pix_ce)
  );
  // Every registered output is decoded from the next (x,y) so it lines up with the new position.
  always_comb begin
    x_d     = reset ? X_LAST : !pix_ce ? x_q : (x_q == X_LAST) ? '0 : x_q + 1'b1;
    y_d     = reset ? Y_LAST : !(pix_ce && x_q == X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    xe      = {1'b0, x_d};
    ye      = {1'b0, y_d};
    hs_d    = (!reset && xe >= HS0 && xe < HS1) ? HS_POL : !HS_POL;
    vs_d    = (!reset && ye >= VS0 && ye < VS1) ? VS_POL : !VS_POL;
    de_d    = !reset && xe < HV && ye < VV;
    ls_d    = !reset && pix_ce && x_d == '0;
    fs_d    = ls_d && y_d == '0;
    fc_d    = reset ? '0 : (fs_d && !first_q) ? fc_q + 1'b1 : fc_q;
    first_d = reset || (first_q && !fs_d);
  end
  always_ff @(posedge CLOCK_50) begin
    x_q     <= x_d;
    y_q     <= y_d;
    hs_q    <= hs_d;
    vs_q    <= vs_d;
    de_q    <= de_d;
    ls_q    <= ls_d;
    fs_q    <= fs_d;
    fc_q    <= fc_d;
    first_q <= first_d;
  end
  assign vga.pix_ce    = pix_ce;
  assign vga.frame_cnt = fc_q;
`ifdef VGA_TIMING_PIPE_EN
  logic [CNT_W-1:0] px_q, py_q;
  logic             phs_q, pvs_q, pde_q, pls_q, pfs_q;
  // Second stage shifts on pix_ce; strobes fire when the stage-one pixel 0 moves across.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      px_q  <= X_LAST;
      py_q  <= Y_LAST;
      phs_q <= !HS_POL;
      pvs_q <= !VS_POL;
      pde_q <= 1'b0;
      pls_q <= 1'b0;
      pfs_q <= 1'b0;
    end else begin
      if (pix_ce) begin
        px_q  <= x_q;
        py_q  <= y_q;
        phs_q <= hs_q;
        pvs_q <= vs_q;
        pde_q <= de_q;
      end
      pls_q <= pix_ce && x_q == '0;
      pfs_q <= pix_ce && x_q == '0 && y_q == '0;
    end
  end
  assign vga.x           = px_q;
  assign vga.y           = py_q;
  assign vga.hsync       = phs_q;
  assign vga.vsync       = pvs_q;
  assign vga.de          = pde_q;
  assign vga.line_start  = pls_q;
  assign vga.frame_start = pfs_q;
`else
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.de          = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table plus arithmetic raster model for a small 15x10 raster at DIV=2 and DIV=1
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 6, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FP = HT * VT;
  localparam int CW = 5, FW = 3;
`ifdef VGA_TIMING_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic          pce;
    logic [FW-1:0] fc;
  } out_t;
  typedef struct {
    int   k;
    out_t o;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[18];
  always #5 clk = ~clk;
  vga_timing_if #(.CNT_W(CW), .FRAME_W(FW)) v2 ();
  vga_timing_if #(.CNT_W(CW), .FRAME_W(FW)) v1 ();
  vga_timing_gen #(
    .DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .FRAME_W(FW)
  ) dut2 (.CLOCK_50(clk), .reset(rst), .vga(v2));
  vga_timing_gen #(
    .DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .FRAME_W(FW)
  ) dut1 (.CLOCK_50(clk), .reset(rst), .vga(v1));
  function automatic out_t cur2();
    return {v2.x, v2.y, v2.hsync, v2.vsync, v2.de, v2.line_start, v2.frame_start, v2.pix_ce, v2.frame_cnt};
  endfunction
  function automatic out_t cur1();
    return {v1.x, v1.y, v1.hsync, v1.vsync, v1.de, v1.line_start, v1.frame_start, v1.pix_ce, v1.frame_cnt};
  endfunction
  // k = clock edges since reset release; pixel advances happen on edges k = DIV, 2*DIV, ...
  function automatic out_t model(int k, int div, bit in_rst);
    out_t o;
    int   p, q, xi, yi;
    bit   adv;
    p   = in_rst ? 0 : k / div;
    adv = !in_rst && k > 0 && (k % div == 0);
    q   = p - LAT;
    xi  = q <= 0 ? HT - 1 : (q - 1) % HT;
    yi  = q <= 0 ? VT - 1 : ((q - 1) / HT) % VT;
    o.x   = CW'(xi);
    o.y   = CW'(yi);
    o.hs  = !(xi >= HV + HF && xi < HV + HF + HSW);
    o.vs  = !(yi >= VV + VF && yi < VV + VF + VSW);
    o.de  = xi < HV && yi < VV;
    o.ls  = adv && q > 0 && xi == 0;
    o.fs  = o.ls && yi == 0;
    o.pce = in_rst ? (div == 1) : (k % div == div - 1);
    o.fc  = FW'(p > 0 ? (p - 1) / FP : 0);
    return o;
  endfunction
  function automatic string fmt(out_t o);
    return $sformatf("x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b pce=%0b fc=%0d",
                     o.x, o.y, o.hs, o.vs, o.de, o.ls, o.fs, o.pce, o.fc);
  endfunction
  task automatic chk(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask
  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ti, de_cnt, ls_cnt, hs_lo, hmin, hmax, fs_prev, fs_per, n;
    tbl[0]  = '{0,    '{14, 9, 1, 1, 0, 0, 0, 0, 0}};
    tbl[1]  = '{1,    '{14, 9, 1, 1, 0, 0, 0, 1, 0}};
    tbl[2]  = '{2,    '{0,  0, 1, 1, 1, 1, 1, 0, 0}};
    tbl[3]  = '{3,    '{0,  0, 1, 1, 1, 0, 0, 1, 0}};
    tbl[4]  = '{4,    '{1,  0, 1, 1, 1, 0, 0, 0, 0}};
    tbl[5]  = '{20,   '{9,  0, 1, 1, 0, 0, 0, 0, 0}};
    tbl[6]  = '{22,   '{10, 0, 0, 1, 0, 0, 0, 0, 0}};
    tbl[7]  = '{26,   '{12, 0, 0, 1, 0, 0, 0, 0, 0}};
    tbl[8]  = '{28,   '{13, 0, 1, 1, 0, 0, 0, 0, 0}};
    tbl[9]  = '{32,   '{0,  1, 1, 1, 1, 1, 0, 0, 0}};
    tbl[10] = '{33,   '{0,  1, 1, 1, 1, 0, 0, 1, 0}};
    tbl[11] = '{212,  '{0,  7, 1, 0, 0, 1, 0, 0, 0}};
    tbl[12] = '{242,  '{0,  8, 1, 0, 0, 1, 0, 0, 0}};
    tbl[13] = '{272,  '{0,  9, 1, 1, 0, 1, 0, 0, 0}};
    tbl[14] = '{300,  '{14, 9, 1, 1, 0, 0, 0, 0, 0}};
    tbl[15] = '{302,  '{0,  0, 1, 1, 1, 1, 1, 0, 1}};
    tbl[16] = '{2102, '{0,  0, 1, 1, 1, 1, 1, 0, 7}};
    tbl[17] = '{2402, '{0,  0, 1, 1, 1, 1, 1, 0, 0}};
    de_cnt = 0; ls_cnt = 0; hs_lo = 0; hmin = 99; hmax = -1; fs_prev = 0; fs_per = 0;
    repeat (3) step();
    chk("reset_div2", cur2(), tbl[0].o);
    chk("reset_div1", cur1(), model(0, 1, 1'b1));
    rst = 1'b0;
    ti = 1;
    for (int k = 1; k <= 2800; k++) begin
      step();
      chk($sformatf("model_div2_k%0d", k), cur2(), model(k, 2, 1'b0));
      chk($sformatf("model_div1_k%0d", k), cur1(), model(k, 1, 1'b0));
`ifndef VGA_TIMING_PIPE_EN
      while (ti < 18 && tbl[ti].k == k) begin
        chk($sformatf("vec_k%0d", k), cur2(), tbl[ti].o);
        ti++;
      end
      if (k >= 2 && k <= 301) begin
        de_cnt += int'(v2.de);
        ls_cnt += int'(v2.line_start);
      end
      if (k >= 2 && k <= 31 && !v2.hsync) begin
        hs_lo++;
        hmin = int'(v2.x) < hmin ? int'(v2.x) : hmin;
        hmax = int'(v2.x) > hmax ? int'(v2.x) : hmax;
      end
      if (v2.frame_start) begin
        if (fs_prev > 0 && fs_per == 0) fs_per = k - fs_prev;
        fs_prev = k;
      end
`endif
    end
`ifndef VGA_TIMING_PIPE_EN
    chk_int("table_applied", ti, 18);
    chk_int("de_clocks_per_frame", de_cnt, HV * VV * 2);
    chk_int("line_starts_per_frame", ls_cnt, VT);
    chk_int("hsync_low_clocks", hs_lo, HSW * 2);
    chk_int("hsync_first_x", hmin, HV + HF);
    chk_int("hsync_last_x", hmax, HV + HF + HSW - 1);
    chk_int("frame_start_period", fs_per, FP * 2);
`endif
    n = 0;
    while (!(v2.x == CW'(11) && v2.y == CW'(7)) && n < 400) begin
      step();
      n++;
    end
    chk_int("reach_x11_y7", int'(v2.x == CW'(11) && v2.y == CW'(7)), 1);
    chk_int("sync_active_before_reset", int'({v2.hsync, v2.vsync}), 0);
    chk_int("frame_cnt_before_reset", int'(v2.frame_cnt), 1);
    rst = 1'b1;
    step();
    chk("midframe_reset_div2", cur2(), '{14, 9, 1, 1, 0, 0, 0, 0, 0});
    chk("midframe_reset_div1", cur1(), '{14, 9, 1, 1, 0, 0, 0, 1, 0});
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("restart_div2_k%0d", k), cur2(), model(k, 2, 1'b0));
      chk($sformatf("restart_div1_k%0d", k), cur1(), model(k, 1, 1'b0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
